// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory
// and buffers returned words in a small FIFO presented to the decoder.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_8000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_b,
  output logic [31:0] inst_pc
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic          grant;
  logic          push;
  logic          pop;
  logic [CW-1:0] credit;
  logic          redir_unused;

  assign redir_unused = ^redirect_pc[1:0];

  assign count      = wr_ptr - rd_ptr;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;

  // Slots that will still be occupied after this edge, counting the word in flight.
  assign credit = {1'b0, count} - CW'(pop) + CW'(inflight);

  always_comb begin
    imem_req = 1'b0;
    if (rstn && !redirect_valid && (credit < CW'(DEPTH)))
      imem_req = 1'b1;
  end

  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;
  assign push      = imem_rvalid && inflight && !redirect_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= grant;
      if (grant) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
      end
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr[AW-1:0]] <= imem_rdata;
      mem_pc[wr_ptr[AW-1:0]]   <= inflight_pc;
    end
  end

  assign inst_b  = inst_valid ? mem_inst[rd_ptr[AW-1:0]] : NOP;
  assign inst_pc = inst_valid ? mem_pc[rd_ptr[AW-1:0]]   : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a one-cycle memory model plus a scoreboard of
// granted {pc, inst} pairs, compared as the decoder side pops them.
module tb_fetch_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] PAT   = 32'hA5A5_0000;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_b;
  logic [31:0] inst_pc;

  int          n_checks = 0;
  int          n_err    = 0;
  int          n_gnt    = 0;
  logic [31:0] ga_prev  = '0;
  logic [63:0] sb_q [$];
  logic [31:0] hold_addr;

  fetch_stage #(.RESET_PC(32'h0000_8000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_b         (inst_b),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample mid-cycle, update scoreboard, then play memory after the edge.
  task automatic cycle();
    logic        g;
    logic [31:0] ga;
    logic [63:0] e;
    @(negedge clk);
    g  = rstn && imem_req && imem_gnt;
    ga = imem_addr;
    if (!rstn || redirect_valid) begin
      sb_q.delete();
    end else if (inst_valid && inst_ready) begin
      chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_pc", inst_pc, e[63:32]);
        chk("sb_inst", inst_b, e[31:0]);
      end
    end
    if (g) begin
      sb_q.push_back({ga, ga ^ PAT});
      n_gnt++;
      chk("no_overflow", 32'(sb_q.size() <= DEPTH), 32'd1);
    end
    @(posedge clk);
    #1;
    imem_rvalid = g;
    imem_rdata  = g ? (ga ^ PAT) : 32'hDEAD_BEEF;
    if (g) ga_prev = ga;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    rstn           = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    repeat (3) cycle();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_b", inst_b, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // Reset fetch
    rstn = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;
    #1;
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0000_8000);
    cycle();
    chk("t1_c1_valid", 32'(inst_valid), 32'd0);
    cycle();
    chk("t1_c2_valid", 32'(inst_valid), 32'd1);
    chk("t1_c2_pc", inst_pc, 32'h0000_8000);
    chk("t1_c2_inst", inst_b, 32'hA5A5_8000);
    cycle();
    chk("t1_c3_pc", inst_pc, 32'h0000_8004);
    cycle();
    chk("t1_c4_pc", inst_pc, 32'h0000_8008);
    chk("t1_c4_inst", inst_b, 32'hA5A5_8008);

    // Back-pressure
    do_reset();
    rstn = 1'b1; inst_ready = 1'b0; imem_gnt = 1'b1; n_gnt = 0;
    repeat (10) cycle();
    chk("t2_grants", 32'(n_gnt), 32'd4);
    chk("t2_req_low", 32'(imem_req), 32'd0);
    chk("t2_head", inst_pc, 32'h0000_8000);
    inst_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 32'(inst_valid), 32'd1);
      chk("t2_pc_seq", inst_pc, 32'h0000_8000 + 32'(4 * i));
      cycle();
    end

    // Grant stall
    imem_gnt = 1'b0;
    #1;
    hold_addr = imem_addr;
    chk("t3_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t3_addr_stable", imem_addr, hold_addr);
      if (!inst_valid) break;
    end
    chk("t3_drained", 32'(inst_valid), 32'd0);
    chk("t3_req_held", 32'(imem_req), 32'd1);

    // Redirect with response in flight
    do_reset();
    rstn = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (imem_rvalid && ga_prev == 32'h0000_8010) break;
      cycle();
    end
    chk("t4_rvalid_8010", ga_prev, 32'h0000_8010);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_9003;
    #1;
    chk("t4_req_redir", 32'(imem_req), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("t4_r1_valid", 32'(inst_valid), 32'd0);
    chk("t4_r1_req", 32'(imem_req), 32'd1);
    chk("t4_r1_addr", imem_addr, 32'h0000_9000);
    cycle();
    chk("t4_r2_valid", 32'(inst_valid), 32'd0);
    cycle();
    chk("t4_r3_valid", 32'(inst_valid), 32'd1);
    chk("t4_r3_pc", inst_pc, 32'h0000_9000);
    chk("t4_r3_inst", inst_b, 32'hA5A5_9000);

    // Redirect plus pop with three entries queued
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (!imem_req) break;
    end
    chk("t5_full_req", 32'(imem_req), 32'd0);
    cycle();
    inst_ready = 1'b1; imem_gnt = 1'b0;
    cycle();
    chk("t5_queued", inst_pc, 32'h0000_9004);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_A000; imem_gnt = 1'b1;
    #1;
    chk("t5_req_redir", 32'(imem_req), 32'd0);
    cycle();
    redirect_valid = 1'b0;
    #1;
    chk("t5_r1_valid", 32'(inst_valid), 32'd0);
    chk("t5_r1_addr", imem_addr, 32'h0000_A000);
    cycle();
    chk("t5_r2_valid", 32'(inst_valid), 32'd0);
    cycle();
    chk("t5_r3_pc", inst_pc, 32'h0000_A000);
    chk("t5_r3_inst", inst_b, 32'hA5A5_A000);

    // Mid-operation reset with a fetch in flight
    inst_ready = 1'b0;
    cycle();
    cycle();
    chk("t6_pre_valid", 32'(inst_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_valid", 32'(inst_valid), 32'd0);
    chk("t6_inst_b", inst_b, 32'h0000_0013);
    chk("t6_inst_pc", inst_pc, 32'h0);
    cycle();
    rstn = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    inst_ready = 1'b1; imem_gnt = 1'b1;
    #1;
    chk("t6_restart_addr", imem_addr, 32'h0000_8000);
    chk("t6_restart_req", 32'(imem_req), 32'd1);
    cycle();
    chk("t6_stale_dropped", 32'(inst_valid), 32'd0);
    cycle();
    chk("t6_c2_pc", inst_pc, 32'h0000_8000);
    chk("t6_c2_inst", inst_b, 32'hA5A5_8000);
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the risky2 core. It sits directly upstream of `decoder`. It owns the program counter and issues word requests to instruction memory. Returned instruction words are buffered in a small FIFO, and each is presented as `inst_b` together with its PC under a valid/ready handshake. Branch and jump resolution redirects the PC, and the redirect flushes both the FIFO and any fetch still in flight.

## Interface
- `RESET_PC`, 32'h0000_8000, PC fetched first after reset.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  word address of the request; bits [1:0] always 0.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; always exactly one cycle after a grant.
- `imem_rdata`  in  32  instruction word returned.
- `redirect_valid`  in  1  taken branch or jump from execute.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored and treated as 0.
- `inst_valid`  out  1  FIFO head valid.
- `inst_ready`  in  1  decoder consumes the head this cycle.
- `inst_b`  out  32  head instruction; 32'h0000_0013 (NOP) when empty.
- `inst_pc`  out  32  head PC; 0 when empty.

## Operation
- Registers:
  - `pc`: next address to request.
  - `inflight`: 1 bit, set when a request is granted.
  - `inflight_pc`: PC of the granted request.
  - FIFO: `DEPTH` entries of {pc, inst}, read/write pointers of width log2(`DEPTH`)+1.
- Credit rule: `imem_req` = !`redirect_valid` && (count − (`inst_valid`&&`inst_ready`) + `inflight`) < `DEPTH`. `count` is the occupancy before this edge.
- `imem_addr` = `pc`.
- On a grant (`imem_req`&&`imem_gnt`):
  - `pc` ← `pc`+4, wrapping modulo 2^32.
  - `inflight` ← 1 and `inflight_pc` ← `pc`.
- With no grant, `inflight` ← 0 at the next edge.
- On `imem_rvalid` with `inflight`=1 and no redirect: push {`inflight_pc`, `imem_rdata`}.
- An `imem_rvalid` with `inflight`=0 is ignored.
- The credit rule guarantees a push never meets a full FIFO. No overflow path is required; the bench asserts it.
- Pop when `inst_valid`&&`inst_ready`. Push and pop in the same cycle leave `count` unchanged.
- `redirect_valid` has highest priority. At that edge:
  - FIFO emptied: pointers reset, `inst_valid`=0 next cycle.
  - `pc` ← {`redirect_pc`[31:2], 2'b00}.
  - `inflight` ← 0.
  - Any `imem_rvalid` arriving in the redirect cycle is dropped.
  - A same-cycle `inst_ready` pop is ignored, since the flush supersedes it.
  - `imem_req` is held 0 during the redirect cycle.
- Back-to-back redirects: the last one wins. No request issues until `redirect_valid` is low.
- Reset (asynchronous, any time, including mid-fetch):
  - `pc`=`RESET_PC`, `inflight`=0, FIFO empty.
  - `imem_req`=0 while `rstn`=0.
  - `inst_valid`=0, `inst_b`=32'h13, `inst_pc`=0.
  - A response arriving after reset release for a pre-reset grant is discarded, because `inflight`=0.

## Timing
- First request is in the first cycle with `rstn` high, at `imem_addr`=`RESET_PC`.
- Grant at edge N, `imem_rvalid` in cycle N+1, push at edge N+1, `inst_valid` in cycle N+2. Request-to-valid latency is 2 cycles, with no bypass.
- Steady state with `imem_gnt`=1 and `inst_ready`=1 gives one instruction per cycle for any `DEPTH`≥2.
- Redirect at edge R: `inst_valid`=0 and `imem_req`=1 at `redirect_pc` in cycle R+1. The first redirected instruction is valid in cycle R+3.
- `inst_b`/`inst_pc` are registered FIFO outputs and hold stable while `inst_valid`&&!`inst_ready`.
- `imem_addr` holds stable while `imem_req`&&!`imem_gnt`.

## Test plan
- **Reset fetch:** `imem_gnt`=1 constantly, memory returns addr^32'hA5A5_0000, `inst_ready`=1.
  - Expect `inst_pc` 0x8000, 0x8004, 0x8008 on consecutive cycles, the first in cycle 2 after reset release.
  - Expect `inst_b` to match the memory pattern.
- **Back-pressure:** `inst_ready`=0 for 10 cycles.
  - Expect exactly `DEPTH`=4 pushes and `imem_req` to fall after 4 grants.
  - Head stays at 0x8000.
  - On release, PCs continue 0x8000…0x800C, then 0x8010 with no gap or duplicate.
- **Grant stall:** `imem_gnt`=0 for 3 cycles with `imem_req`=1.
  - Expect `imem_addr` stable, no `inflight`, and the FIFO drains to `inst_valid`=0.
- **Redirect with response in flight:** `redirect_valid`=1, `redirect_pc`=0x9003, asserted in the same cycle as an `imem_rvalid` for 0x8010.
  - Expect the 0x8010 word never to appear.
  - Expect next `imem_addr`=0x9000, next `inst_pc`=0x9000.
- **Redirect plus pop:** redirect together with `inst_ready`=1 while 3 entries are queued.
  - Expect all entries flushed, then `inst_valid`=0 for 2 cycles.
- **Mid-operation reset:** `rstn` low asynchronously between edges while `inflight`=1 and the FIFO is non-empty.
  - Expect outputs to reach reset values immediately.
  - After release, expect the stale `imem_rvalid` to be ignored and fetch to restart at 0x8000.
